// File: rtl/cla_pipe_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// out_zero is present only when CLA_PIPE_ZERO_FLAG_EN is defined.
interface cla_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
`ifdef CLA_PIPE_ZERO_FLAG_EN
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`endif
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one SEG-bit segment per stage.
// Optional zero flag (out_zero) enabled by defining CLA_PIPE_ZERO_FLAG_EN.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic       clk,
  input logic       rst,
  cla_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;

  if ((WIDTH % SEG) != 0 || (SEG % 4) != 0 || SEG < 4) begin : g_param_chk
    $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of SEG, SEG a multiple of 4");
  end

  // 4-bit lookahead groups, carry rippled from group to group.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           ci);
    logic [SEG-1:0] p, g, s;
    logic [4:0]     gc;
    logic           c;
    p = a ^ b;
    g = a & b;
    s = '0;
    c = ci;
    for (int j = 0; j < SEG; j += 4) begin
      gc[0] = c;
      gc[1] = g[j] | (p[j] & c);
      gc[2] = g[j+1] | (p[j+1] & g[j]) | (p[j+1] & p[j] & c);
      gc[3] = g[j+2] | (p[j+2] & g[j+1]) | (p[j+2] & p[j+1] & g[j])
            | (p[j+2] & p[j+1] & p[j] & c);
      gc[4] = g[j+3] | (p[j+3] & g[j+2]) | (p[j+3] & p[j+2] & g[j+1])
            | (p[j+3] & p[j+2] & p[j+1] & g[j])
            | (p[j+3] & p[j+2] & p[j+1] & p[j] & c);
      s[j +: 4] = p[j +: 4] ^ gc[3:0];
      c = gc[4];
    end
    return {c, s};
  endfunction

  function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb ~^ b_msb) & (a_msb ^ s_msb);
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = (k + 1) * SEG;
    localparam int RW = WIDTH - k * SEG;

    logic [RW-1:0] rem_a;
    logic [RW-1:0] rem_b;
    logic          ci;
    logic          vld_in;
    logic          ld;
    logic [SEG:0]  seg_r;
    logic [LO-1:0] sum_d;
    logic          vld_q;
    logic          cy_q;
    logic [LO-1:0] sum_q;

    // Stage inputs: ports for the head stage, previous stage registers otherwise.
    if (k == 0) begin : g_src
      assign rem_a  = bus.in_a;
      assign rem_b  = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign ci     = bus.in_sub | bus.in_cin;
      assign vld_in = bus.in_valid;
      assign sum_d  = seg_r[SEG-1:0];
    end else begin : g_src
      assign rem_a  = g_stg[k-1].g_skew.a_q;
      assign rem_b  = g_stg[k-1].g_skew.b_q;
      assign ci     = g_stg[k-1].cy_q;
      assign vld_in = g_stg[k-1].vld_q;
      assign sum_d  = {seg_r[SEG-1:0], g_stg[k-1].sum_q};
    end

    if (k == STAGES - 1) begin : g_ld
      assign ld = ~vld_q | bus.out_ready;
    end else begin : g_ld
      assign ld = ~vld_q | g_stg[k+1].ld;
    end

    assign seg_r = seg_add(rem_a[SEG-1:0], rem_b[SEG-1:0], ci);

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (ld) begin
        vld_q <= vld_in;
        if (vld_in) begin
          cy_q  <= seg_r[SEG];
          sum_q <= sum_d;
        end
      end
    end

    // Skewed operand slices for later stages; the last stage keeps the overflow flag.
    if (k < STAGES - 1) begin : g_skew
      logic [RW-SEG-1:0] a_q;
      logic [RW-SEG-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld & vld_in) begin
          a_q <= rem_a[RW-1:SEG];
          b_q <= rem_b[RW-1:SEG];
        end
      end
    end else begin : g_tail
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (ld & vld_in) begin
          ovf_q <= ovf_flag(rem_a[RW-1], rem_b[RW-1], seg_r[SEG-1]);
        end
      end
    end

`ifdef CLA_PIPE_ZERO_FLAG_EN
    logic z_d;
    logic z_q;
    if (k == 0) begin : g_zs
      assign z_d = ~|seg_r[SEG-1:0];
    end else begin : g_zs
      assign z_d = ~|seg_r[SEG-1:0] & g_stg[k-1].z_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        z_q <= 1'b0;
      end else if (ld & vld_in) begin
        z_q <= z_d;
      end
    end
`endif
  end

  assign bus.in_ready  = g_stg[0].ld & ~rst;
  assign bus.out_valid = g_stg[STAGES-1].vld_q;
  assign bus.out_sum   = g_stg[STAGES-1].sum_q;
  assign bus.out_cout  = g_stg[STAGES-1].cy_q;
  assign bus.out_ovf   = g_stg[STAGES-1].g_tail.ovf_q;
`ifdef CLA_PIPE_ZERO_FLAG_EN
  assign bus.out_zero  = g_stg[STAGES-1].z_q;
`endif

endmodule
